// File: rtl/router_pkg.sv
// Shared types and constants for the 1x3 router packet-sequencing controller.
package router_pkg;

    localparam int ADDR_W = 2;
    localparam logic [1:0] ADDR_INVALID = 2'b11;

    typedef enum logic [2:0] {
        DECODE_ADDRESS     = 3'd0,
        LOAD_FIRST_DATA    = 3'd1,
        LOAD_DATA          = 3'd2,
        FIFO_FULL_STATE    = 3'd3,
        LOAD_AFTER_FULL    = 3'd4,
        LOAD_PARITY        = 3'd5,
        CHECK_PARITY_ERROR = 3'd6,
        WAIT_TILL_EMPTY    = 3'd7
    } router_state_t;

endpackage

// File: rtl/router_fsm.sv
// Packet-sequencing FSM for the 1x3 router: header decode, payload, parity, check.
// Optional completed-packet counter enabled by defining ROUTER_FSM_PKT_CNT_EN.
module router_fsm
    import router_pkg::*;
#(
    parameter int ADDR_W = 2
`ifdef ROUTER_FSM_PKT_CNT_EN
    ,
    parameter int CNT_W  = 16
`endif
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              pkt_valid,
    input  logic [ADDR_W-1:0] data_in,
    input  logic              fifo_full,
    input  logic              fifo_empty_0,
    input  logic              fifo_empty_1,
    input  logic              fifo_empty_2,
    input  logic              soft_reset_0,
    input  logic              soft_reset_1,
    input  logic              soft_reset_2,
    input  logic              parity_done,
    input  logic              low_pkt_valid,
    output logic              busy,
    output logic              detect_add,
    output logic              lfd_state,
    output logic              ld_state,
    output logic              laf_state,
    output logic              full_state,
    output logic              write_enb_reg,
    output logic              rst_int_reg
`ifdef ROUTER_FSM_PKT_CNT_EN
    ,
    output logic [CNT_W-1:0]  pkt_count
`endif
);

    router_state_t     state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              empty_sel;
    logic              soft_rst_sel;
    logic [ADDR_W-1:0] empty_addr;
    logic              hdr_ok;

    // In DECODE_ADDRESS the header is still on data_in; elsewhere use the latched address.
    always_comb begin
        empty_addr = (state_q == DECODE_ADDRESS) ? data_in : addr_q;
        empty_sel  = 1'b0;
        if (empty_addr == ADDR_W'(0)) empty_sel = fifo_empty_0;
        else if (empty_addr == ADDR_W'(1)) empty_sel = fifo_empty_1;
        else if (empty_addr == ADDR_W'(2)) empty_sel = fifo_empty_2;
    end

    always_comb begin
        soft_rst_sel = 1'b0;
        if (addr_q == ADDR_W'(0)) soft_rst_sel = soft_reset_0;
        else if (addr_q == ADDR_W'(1)) soft_rst_sel = soft_reset_1;
        else if (addr_q == ADDR_W'(2)) soft_rst_sel = soft_reset_2;
    end

    assign hdr_ok = pkt_valid && (data_in != ADDR_W'(ADDR_INVALID));

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        if (state_q == DECODE_ADDRESS && pkt_valid)
            addr_d = data_in;
        unique case (state_q)
            DECODE_ADDRESS:
                if (hdr_ok) state_d = empty_sel ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            LOAD_FIRST_DATA:
                state_d = LOAD_DATA;
            LOAD_DATA:
                if (fifo_full)       state_d = FIFO_FULL_STATE;
                else if (!pkt_valid) state_d = LOAD_PARITY;
            FIFO_FULL_STATE:
                if (!fifo_full) state_d = LOAD_AFTER_FULL;
            LOAD_AFTER_FULL:
                if (parity_done)        state_d = DECODE_ADDRESS;
                else if (low_pkt_valid) state_d = LOAD_PARITY;
                else                    state_d = LOAD_DATA;
            LOAD_PARITY:
                state_d = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
                state_d = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            WAIT_TILL_EMPTY:
                if (empty_sel) state_d = LOAD_FIRST_DATA;
            default:
                state_d = DECODE_ADDRESS;
        endcase
        // Timeout of the addressed FIFO abandons the packet from any active state.
        if (state_q != DECODE_ADDRESS && soft_rst_sel)
            state_d = DECODE_ADDRESS;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= DECODE_ADDRESS;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

`ifdef ROUTER_FSM_PKT_CNT_EN
    logic [CNT_W-1:0] pkt_count_q, pkt_count_d;

    // CHECK_PARITY_ERROR never loops on itself, so entering it is just state_d hitting it.
    always_comb begin
        pkt_count_d = pkt_count_q;
        if (state_d == CHECK_PARITY_ERROR && state_q != CHECK_PARITY_ERROR)
            pkt_count_d = pkt_count_q + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) pkt_count_q <= '0;
        else       pkt_count_q <= pkt_count_d;
    end

    assign pkt_count = pkt_count_q;
`endif

    assign detect_add    = (state_q == DECODE_ADDRESS);
    assign lfd_state     = (state_q == LOAD_FIRST_DATA);
    assign ld_state      = (state_q == LOAD_DATA);
    assign full_state    = (state_q == FIFO_FULL_STATE);
    assign laf_state     = (state_q == LOAD_AFTER_FULL);
    assign rst_int_reg   = (state_q == CHECK_PARITY_ERROR);
    assign write_enb_reg = (state_q == LOAD_DATA) || (state_q == LOAD_PARITY)
                        || (state_q == LOAD_AFTER_FULL);
    assign busy          = !((state_q == DECODE_ADDRESS) || (state_q == LOAD_DATA));

endmodule

// File: tb/tb_router_fsm.sv
// Directed self-checking bench for router_fsm; strobes are checked as one packed vector.
module tb_router_fsm;

    // {detect_add, lfd, ld, full, laf, rst_int, write_enb, busy}
    localparam logic [7:0] S_DA  = 8'b1000_0000;
    localparam logic [7:0] S_LFD = 8'b0100_0001;
    localparam logic [7:0] S_LD  = 8'b0010_0010;
    localparam logic [7:0] S_FUL = 8'b0001_0001;
    localparam logic [7:0] S_LAF = 8'b0000_1011;
    localparam logic [7:0] S_LP  = 8'b0000_0011;
    localparam logic [7:0] S_CHK = 8'b0000_0101;
    localparam logic [7:0] S_WTE = 8'b0000_0001;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       pkt_valid = 1'b0;
    logic [1:0] data_in = 2'd0;
    logic       fifo_full = 1'b0;
    logic       fifo_empty_0 = 1'b0, fifo_empty_1 = 1'b0, fifo_empty_2 = 1'b0;
    logic       soft_reset_0 = 1'b0, soft_reset_1 = 1'b0, soft_reset_2 = 1'b0;
    logic       parity_done = 1'b0;
    logic       low_pkt_valid = 1'b0;
    logic       busy, detect_add, lfd_state, ld_state, laf_state, full_state;
    logic       write_enb_reg, rst_int_reg;
`ifdef ROUTER_FSM_PKT_CNT_EN
    logic [15:0] pkt_count;
`endif

    int n_chk  = 0;
    int n_fail = 0;
    int wen_cnt, rst_cnt;

    router_fsm dut (
        .clock(clock), .reset(reset), .pkt_valid(pkt_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
        .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
        .busy(busy), .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .write_enb_reg(write_enb_reg),
        .rst_int_reg(rst_int_reg)
`ifdef ROUTER_FSM_PKT_CNT_EN
        , .pkt_count(pkt_count)
`endif
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] strobes();
        return {detect_add, lfd_state, ld_state, full_state, laf_state,
                rst_int_reg, write_enb_reg, busy};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
        if (write_enb_reg) wen_cnt++;
        if (rst_int_reg)   rst_cnt++;
    endtask

    // Clean packet on an empty FIFO: header, npay extra payload cycles in LD, parity, check.
    task automatic run_packet(input logic [1:0] addr, input int npay);
        pkt_valid = 1'b1; data_in = addr; fifo_empty_0 = 1'b1;
        fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        tick(); check("pkt_lfd", 32'(strobes()), 32'(S_LFD));
        tick(); check("pkt_ld", 32'(strobes()), 32'(S_LD));
        for (int i = 1; i < npay; i++) tick();
        pkt_valid = 1'b0;
        tick(); check("pkt_lp", 32'(strobes()), 32'(S_LP));
        tick(); check("pkt_chk", 32'(strobes()), 32'(S_CHK));
        tick(); check("pkt_da", 32'(strobes()), 32'(S_DA));
    endtask

    initial begin
        #12 reset = 1'b0;
        check("reset_state", 32'(strobes()), 32'(S_DA));

        // Addr 1 packet: LFD, LD x3, LP, CHK, DA
        wen_cnt = 0; rst_cnt = 0;
        pkt_valid = 1'b1; data_in = 2'd1; fifo_empty_1 = 1'b1;
        tick(); check("p1_lfd", 32'(strobes()), 32'(S_LFD));
        data_in = 2'd2;
        tick(); check("p1_ld1", 32'(strobes()), 32'(S_LD));
        tick(); check("p1_ld2", 32'(strobes()), 32'(S_LD));
        tick(); check("p1_ld3", 32'(strobes()), 32'(S_LD));
        pkt_valid = 1'b0;
        tick(); check("p1_lp", 32'(strobes()), 32'(S_LP));
        tick(); check("p1_chk", 32'(strobes()), 32'(S_CHK));
        tick(); check("p1_da", 32'(strobes()), 32'(S_DA));
        check("p1_wen_cycles", 32'(wen_cnt), 32'd4);
        check("p1_rst_pulses", 32'(rst_cnt), 32'd1);

        // Addr 2 with non-empty FIFO: 5 cycles of WAIT_TILL_EMPTY
        fifo_empty_1 = 1'b0; fifo_empty_2 = 1'b0;
        pkt_valid = 1'b1; data_in = 2'd2;
        for (int i = 0; i < 5; i++) begin
            tick(); check("p2_wte", 32'(strobes()), 32'(S_WTE));
            data_in = 2'd0;
        end
        fifo_empty_2 = 1'b1;
        tick(); check("p2_lfd", 32'(strobes()), 32'(S_LFD));
        tick(); check("p2_ld", 32'(strobes()), 32'(S_LD));

        // Full for 3 cycles mid-payload
        fifo_full = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(); check("p2_full", 32'(strobes()), 32'(S_FUL));
        end
        fifo_full = 1'b0;
        tick(); check("p2_laf", 32'(strobes()), 32'(S_LAF));
        pkt_valid = 1'b0; low_pkt_valid = 1'b1; parity_done = 1'b0;
        tick(); check("p2_lp", 32'(strobes()), 32'(S_LP));
        low_pkt_valid = 1'b0;
        tick(); check("p2_chk", 32'(strobes()), 32'(S_CHK));
        tick(); check("p2_da", 32'(strobes()), 32'(S_DA));

        // Invalid header address stays put with no write enable
        pkt_valid = 1'b1; data_in = 2'd3;
        tick(); check("bad_addr_da", 32'(strobes()), 32'(S_DA));
        tick(); check("bad_addr_wen", 32'(write_enb_reg), 32'd0);

        // Soft reset: only the addressed FIFO's timeout matters
        fifo_empty_0 = 1'b0; data_in = 2'd0;
        tick(); check("sr_wte", 32'(strobes()), 32'(S_WTE));
        pkt_valid = 1'b0;
        soft_reset_1 = 1'b1;
        tick(); check("sr_other_ignored", 32'(strobes()), 32'(S_WTE));
        soft_reset_1 = 1'b0; soft_reset_0 = 1'b1;
        tick(); check("sr_own_abort", 32'(strobes()), 32'(S_DA));
        soft_reset_0 = 1'b0;

        // Async reset in LOAD_DATA aborts before the next edge
        pkt_valid = 1'b1; data_in = 2'd0; fifo_empty_0 = 1'b1;
        tick(); check("ar_lfd", 32'(strobes()), 32'(S_LFD));
        tick(); check("ar_ld", 32'(strobes()), 32'(S_LD));
        #2 reset = 1'b1;
        #1 check("ar_async_da", 32'(strobes()), 32'(S_DA));
        check("ar_no_wen", 32'(write_enb_reg), 32'd0);
        pkt_valid = 1'b0;
        @(negedge clock); reset = 1'b0;

`ifdef ROUTER_FSM_PKT_CNT_EN
        check("cnt_reset", 32'(pkt_count), 32'd0);
        run_packet(2'd1, 2);
        check("cnt_one", 32'(pkt_count), 32'd1);
        run_packet(2'd2, 1);
        check("cnt_two", 32'(pkt_count), 32'd2);
`else
        run_packet(2'd1, 2);
        run_packet(2'd2, 1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
